// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the programmable sync FIFO.
// Error-flag bit positions are exported so a status-register block can
// pack overflow/underflow with the same layout as the FIFO uses internally.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  // Error flag vector layout
  localparam int ERR_OVERFLOW_BIT  = 0;
  localparam int ERR_UNDERFLOW_BIT = 1;
  localparam int ERR_W             = 2;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: producer/consumer bundle for sync_fifo_prog.
// master = the user side driving requests, slave = the FIFO itself.
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, data_in, rd_en,
    input  data_out, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, data_in, rd_en,
    output data_out, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog_ram.sv
// fifo_ram: simple dual-port storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with fill count, programmable
// almost-full/almost-empty, sticky overflow/underflow and synchronous flush.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads; without it data_out is registered with a one-cycle rd_valid strobe.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                full_w, empty_w;
  logic                wr_acc, rd_acc;
  logic [CNT_W-1:0]    count_w;
  logic [DATA_W-1:0]   ram_rdata;

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count_w = CNT_W'(wr_ptr_q - rd_ptr_q);
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc && !bus.clr),
    .waddr (wr_ptr_q[PTR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Next pointers and sticky error flags; clr overrides both requests
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      err_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.wr_en && full_w)  err_d[ERR_OVERFLOW_BIT]  = 1'b1;
      if (bus.rd_en && empty_w) err_d[ERR_UNDERFLOW_BIT] = 1'b1;
    end
  end

  // Pointer and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only acknowledges it
  assign bus.data_out = ram_rdata;
  assign bus.rd_valid = !empty_w;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;

  // Registered read path: capture head word on the accepting edge
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    if (!bus.clr && rd_acc) begin
      data_out_d = ram_rdata;
      rd_valid_d = 1'b1;
    end
  end

  // Read data and valid strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.count        = count_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_w >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_w <= CNT_W'(AE_THRESH));
  assign bus.overflow     = err_q[ERR_OVERFLOW_BIT];
  assign bus.underflow    = err_q[ERR_UNDERFLOW_BIT];
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed test of sync_fifo_prog with DEPTH=8,
// AF_THRESH=6, AE_THRESH=2. Expected values are hand-computed constants.
module tb_sync_fifo_prog;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sync_fifo_prog_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_prog #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle state
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ae", 32'(bus.almost_empty), 32'd1);
    check("rst_af", 32'(bus.almost_full), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rdv", 32'(bus.rd_valid), 32'd0);
    check("rst_dout", bus.data_out, 32'd0);
`endif

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: word visible right after the write edge
    bus.wr_en = 1'b1; bus.data_in = 32'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("fwft_dout", bus.data_out, 32'hA5);
    check("fwft_rdv", 32'(bus.rd_valid), 32'd1);
    check("fwft_count", 32'(bus.count), 32'd1);
    tick();
    check("fwft_hold", bus.data_out, 32'hA5);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("fwft_empty", 32'(bus.empty), 32'd1);
    check("fwft_rdv0", 32'(bus.rd_valid), 32'd0);
`endif

    // Fill 0..7, watching threshold crossings
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 32'(i);
      tick();
      check($sformatf("fill%0d_count", i), 32'(bus.count), 32'(i + 1));
      check($sformatf("fill%0d_ae", i), 32'(bus.almost_empty), 32'((i + 1) <= 2));
      check($sformatf("fill%0d_af", i), 32'(bus.almost_full), 32'((i + 1) >= 6));
      check($sformatf("fill%0d_full", i), 32'(bus.full), 32'(i == 7));
    end
    bus.data_in = 32'h99;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd8);

    // Drain 8 words
    for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("rd%0d_peek", i), bus.data_out, 32'(i));
`endif
      bus.rd_en = 1'b1;
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("rd%0d_data", i), bus.data_out, 32'(i));
      check($sformatf("rd%0d_rdv", i), 32'(bus.rd_valid), 32'd1);
`endif
      check($sformatf("rd%0d_count", i), 32'(bus.count), 32'(7 - i));
    end
    bus.rd_en = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
    tick();
    check("idle_rdv", 32'(bus.rd_valid), 32'd0);
    check("unf_pre", 32'(bus.underflow), 32'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("unf_set", 32'(bus.underflow), 32'd1);
    check("unf_ovf_kept", 32'(bus.overflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("unf_dout_hold", bus.data_out, 32'h07);
    check("unf_rdv", 32'(bus.rd_valid), 32'd0);
`endif

    // Flush sticky flags before streaming
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 32'd0);
    check("clr_unf", 32'(bus.underflow), 32'd0);

    // Prime 5 words, then stream through a pointer wrap
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 32'h10 + 32'(i);
      tick();
    end
    check("prime_count", 32'(bus.count), 32'd5);
    for (int k = 0; k < 20; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("st%0d_peek", k), bus.data_out, 32'h10 + 32'(k));
`endif
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 32'h15 + 32'(k);
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("st%0d_data", k), bus.data_out, 32'h10 + 32'(k));
`endif
      check($sformatf("st%0d_count", k), 32'(bus.count), 32'd5);
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("st_ovf", 32'(bus.overflow), 32'd0);
    check("st_unf", 32'(bus.underflow), 32'd0);

    // Drain remaining 0x24..0x28 then underflow
    for (int i = 0; i < 5; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("dr%0d_peek", i), bus.data_out, 32'h24 + 32'(i));
`endif
      bus.rd_en = 1'b1;
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("dr%0d_data", i), bus.data_out, 32'h24 + 32'(i));
`endif
    end
    tick();
    bus.rd_en = 1'b0;
    check("dr_unf", 32'(bus.underflow), 32'd1);

    // Refill to full plus one extra write for overflow
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 32'h40 + 32'(i);
      tick();
    end
    check("refill_full", 32'(bus.full), 32'd1);
    check("refill_ovf", 32'(bus.overflow), 32'd1);

    // clr together with wr_en: flush wins, write discarded
    bus.clr = 1'b1; bus.wr_en = 1'b1; bus.data_in = 32'hEE;
    tick();
    bus.clr = 1'b0; bus.wr_en = 1'b0;
    check("cw_count", 32'(bus.count), 32'd0);
    check("cw_empty", 32'(bus.empty), 32'd1);
    check("cw_ovf", 32'(bus.overflow), 32'd0);
    check("cw_unf", 32'(bus.underflow), 32'd0);
    check("cw_rdv", 32'(bus.rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("cw_dout_hold", bus.data_out, 32'h28);
`endif
    tick();
    check("cw_count_after", 32'(bus.count), 32'd0);

    // Asynchronous reset while holding data
    bus.wr_en = 1'b1; bus.data_in = 32'h77;
    tick();
    bus.wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_empty", 32'(bus.empty), 32'd1);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
